// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID pipeline register with optional two-entry skid buffer, flush and NOP bubbles
module if_id_pipe #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = 'h13,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter bit              SKID      = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic [1:0]      occupancy
);
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;
  logic            accept;
  logic            retire;
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  assign out_pc    = pc_q;
  assign out_instr = out_valid ? instr_q : NOP_INSTR;
  if (SKID) begin : g_skid
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t          state_q;
    logic            in_ready_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [ILEN-1:0] skid_instr_q;
    assign in_ready  = in_ready_q;
    assign out_valid = state_q != EMPTY;
    assign occupancy = state_q;
    // main/skid FSM; in_ready is registered so out_ready never reaches it combinationally
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q    <= EMPTY;
        in_ready_q <= 1'b1;
        pc_q       <= RESET_PC;
        instr_q    <= NOP_INSTR;
      end else if (flush) begin
        state_q    <= EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        case (state_q)
          EMPTY: if (accept) begin
            state_q <= ONE;
            pc_q    <= in_pc;
            instr_q <= in_instr;
          end
          ONE: if (accept && retire) begin
            pc_q    <= in_pc;
            instr_q <= in_instr;
          end else if (accept) begin
            state_q      <= TWO;
            in_ready_q   <= 1'b0;
            skid_pc_q    <= in_pc;
            skid_instr_q <= in_instr;
          end else if (retire) begin
            state_q <= EMPTY;
          end
          TWO: if (retire) begin
            state_q    <= ONE;
            in_ready_q <= 1'b1;
            pc_q       <= skid_pc_q;
            instr_q    <= skid_instr_q;
          end
          default: begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_single
    logic v_q;
    assign in_ready  = !v_q || out_ready;
    assign out_valid = v_q;
    assign occupancy = {1'b0, v_q};
    // single holding register; flush drops both held and offered beats
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q     <= 1'b0;
        pc_q    <= RESET_PC;
        instr_q <= NOP_INSTR;
      end else begin
        v_q <= flush ? 1'b0 : accept ? 1'b1 : retire ? 1'b0 : v_q;
        if (accept && !flush) begin
          pc_q    <= in_pc;
          instr_q <= in_instr;
        end
      end
    end
  end
endmodule
